// File: rtl/sdram_port_arb_pkg.sv
// Shared types for the two-port SDRAM arbiter: FSM encoding, port indices
// and the toggle-handshake pending rule.
package sdram_port_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int   NUM_PORTS = 2;
    localparam logic PORT0     = 1'b0;
    localparam logic PORT1     = 1'b1;

    // A toggle-handshake request is outstanding while req and ack disagree.
    function automatic logic toggle_pending(input logic req, input logic ack);
        return req ^ ack;
    endfunction

endpackage

// File: rtl/sdram_port_arb_if.sv
// Bus bundle for the arbiter: two toggle-handshake client ports and the
// level-handshake controller port. slave = arbiter view, master = clients/controller.
interface sdram_port_arb_if #(
    parameter int addrwidth = 16,
    parameter int datawidth = 16
);
    logic [addrwidth:1]   p0_a;
    logic [datawidth-1:0] p0_q;
    logic [datawidth-1:0] p0_d;
    logic                 p0_rd_req;
    logic                 p0_rd_ack;
    logic                 p0_wr_req;
    logic                 p0_wr_ack;

    logic [addrwidth:1]   p1_a;
    logic [datawidth-1:0] p1_q;
    logic [datawidth-1:0] p1_d;
    logic                 p1_rd_req;
    logic                 p1_rd_ack;
    logic                 p1_wr_req;
    logic                 p1_wr_ack;

    // mem_req is a level held until the one-cycle mem_ack pulse; mem_d is
    // valid only in the mem_ack cycle.
    logic [addrwidth:1]   mem_a;
    logic [datawidth-1:0] mem_q;
    logic                 mem_we;
    logic                 mem_req;
    logic                 mem_ack;
    logic [datawidth-1:0] mem_d;

    modport master (
        output p0_a, p0_q, p0_rd_req, p0_wr_req,
        output p1_a, p1_q, p1_rd_req, p1_wr_req,
        output mem_ack, mem_d,
        input  p0_d, p0_rd_ack, p0_wr_ack,
        input  p1_d, p1_rd_ack, p1_wr_ack,
        input  mem_a, mem_q, mem_we, mem_req
    );

    modport slave (
        input  p0_a, p0_q, p0_rd_req, p0_wr_req,
        input  p1_a, p1_q, p1_rd_req, p1_wr_req,
        input  mem_ack, mem_d,
        output p0_d, p0_rd_ack, p0_wr_ack,
        output p1_d, p1_rd_ack, p1_wr_ack,
        output mem_a, mem_q, mem_we, mem_req
    );

endinterface

// File: rtl/sdram_port_arb_toggle_port.sv
// Per-client state: pending detection, ack toggles, read-data register and
// the completed-transaction counter.
module toggle_port
    import sdram_port_arb_pkg::*;
#(
    parameter int datawidth = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_req_i,
    input  logic                 wr_req_i,
    input  logic                 done_i,
    input  logic                 done_we_i,
    input  logic [datawidth-1:0] mem_d_i,
    output logic                 rd_pend_o,
    output logic                 wr_pend_o,
    output logic                 rd_ack_o,
    output logic                 wr_ack_o,
    output logic [datawidth-1:0] d_o,
    output logic [31:0]          grants_o
);

    logic                 rd_ack_q;
    logic                 wr_ack_q;
    logic [datawidth-1:0] d_q;
    logic [31:0]          grants_q;

    assign rd_pend_o = toggle_pending(rd_req_i, rd_ack_q);
    assign wr_pend_o = toggle_pending(wr_req_i, wr_ack_q);
    assign rd_ack_o  = rd_ack_q;
    assign wr_ack_o  = wr_ack_q;
    assign d_o       = d_q;
    assign grants_o  = grants_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ack_q <= 1'b0;
            wr_ack_q <= 1'b0;
            d_q      <= '0;
            grants_q <= '0;
        end else if (done_i) begin
            if (done_we_i) begin
                wr_ack_q <= ~wr_ack_q;
            end else begin
                rd_ack_q <= ~rd_ack_q;
                d_q      <= mem_d_i;
            end
            grants_q <= grants_q + 32'd1;
        end
    end

endmodule

// File: rtl/sdram_port_arb.sv
// Round-robin arbiter merging two toggle-handshake clients onto one
// level-handshake SDRAM controller port, with a sticky no-ack watchdog.
module sdram_port_arb
    import sdram_port_arb_pkg::*;
#(
    parameter int addrwidth    = 16,
    parameter int datawidth    = 16,
    parameter int timeoutwidth = 10
) (
    input  logic            clk,
    input  logic            reset,
    sdram_port_arb_if.slave bus,
    output logic            timeout,
    output logic [31:0]     grants0,
    output logic [31:0]     grants1,
    output arb_state_e      dbg_state_o
);

    localparam logic [timeoutwidth-1:0] WD_ONE  = 1;
    localparam logic [timeoutwidth-1:0] WD_FULL = '1;

    arb_state_e             state_q;
    logic                   sel_q;
    logic                   last_q;
    logic [addrwidth:1]     mem_a_q;
    logic [datawidth-1:0]   mem_q_q;
    logic                   mem_we_q;
    logic                   mem_req_q;
    logic [timeoutwidth-1:0] wd_q;
    logic [timeoutwidth-1:0] wd_d;
    logic                   timeout_q;

    logic [NUM_PORTS-1:0]   rd_pend;
    logic [NUM_PORTS-1:0]   wr_pend;
    logic [NUM_PORTS-1:0]   pending;
    logic [NUM_PORTS-1:0]   done;
    logic                   pick;
    logic [addrwidth:1]     pick_a;
    logic [datawidth-1:0]   pick_q;

    toggle_port #(.datawidth(datawidth)) u_port0 (
        .clk       (clk),
        .reset     (reset),
        .rd_req_i  (bus.p0_rd_req),
        .wr_req_i  (bus.p0_wr_req),
        .done_i    (done[PORT0]),
        .done_we_i (mem_we_q),
        .mem_d_i   (bus.mem_d),
        .rd_pend_o (rd_pend[PORT0]),
        .wr_pend_o (wr_pend[PORT0]),
        .rd_ack_o  (bus.p0_rd_ack),
        .wr_ack_o  (bus.p0_wr_ack),
        .d_o       (bus.p0_d),
        .grants_o  (grants0)
    );

    toggle_port #(.datawidth(datawidth)) u_port1 (
        .clk       (clk),
        .reset     (reset),
        .rd_req_i  (bus.p1_rd_req),
        .wr_req_i  (bus.p1_wr_req),
        .done_i    (done[PORT1]),
        .done_we_i (mem_we_q),
        .mem_d_i   (bus.mem_d),
        .rd_pend_o (rd_pend[PORT1]),
        .wr_pend_o (wr_pend[PORT1]),
        .rd_ack_o  (bus.p1_rd_ack),
        .wr_ack_o  (bus.p1_wr_ack),
        .d_o       (bus.p1_d),
        .grants_o  (grants1)
    );

    // On a tie the port that did not win last time goes next; otherwise the
    // lone pending port (pending[1] is 0 when only port 0 is waiting).
    always_comb begin
        pending = rd_pend | wr_pend;
        pick    = (pending == 2'b11) ? ~last_q : pending[PORT1];
        done    = '0;
        if (state_q == ST_BUSY && bus.mem_ack) begin
            done[sel_q] = 1'b1;
        end
        wd_d = (wd_q == WD_FULL) ? wd_q : wd_q + WD_ONE;
    end

    assign pick_a = pick ? bus.p1_a : bus.p0_a;
    assign pick_q = pick ? bus.p1_q : bus.p0_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= PORT0;
            last_q    <= PORT1;
            mem_a_q   <= '0;
            mem_q_q   <= '0;
            mem_we_q  <= 1'b0;
            mem_req_q <= 1'b0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|pending) begin
                        sel_q     <= pick;
                        last_q    <= pick;
                        mem_a_q   <= pick_a;
                        mem_q_q   <= pick_q;
                        mem_we_q  <= wr_pend[pick];
                        mem_req_q <= 1'b1;
                        wd_q      <= '0;
                        state_q   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        // Flag is set on the edge the count lands on all-ones.
                        wd_q <= wd_d;
                        if (wd_d == WD_FULL) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_a   = mem_a_q;
    assign bus.mem_q   = mem_q_q;
    assign bus.mem_we  = mem_we_q;
    assign bus.mem_req = mem_req_q;
    assign timeout     = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: directed scenarios plus a randomized run checked
// against a transaction-level model of the round-robin and toggle rules.
module tb_sdram_port_arb;
    import sdram_port_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        timeout;
    logic [31:0] grants0;
    logic [31:0] grants1;
    arb_state_e  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_port_arb_if #(.addrwidth(16), .datawidth(16)) bus ();

    sdram_port_arb #(.addrwidth(16), .datawidth(16), .timeoutwidth(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .timeout     (timeout),
        .grants0     (grants0),
        .grants1     (grants1),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL global_time_limit reached: simulation did not finish");
        $fatal(1, "time limit");
    end

    // Model state: client-side request levels and what each port should show.
    logic        m_rd_req [2];
    logic        m_wr_req [2];
    logic        e_rd_ack [2];
    logic        e_wr_ack [2];
    logic [15:0] e_d      [2];
    logic [31:0] e_grants [2];
    logic [15:0] e_a      [2];
    logic [15:0] e_q      [2];
    logic        e_last;
    logic [0:0]  exp_q[$];

    function automatic logic g_rd_ack(input int p);
        return (p == 0) ? bus.p0_rd_ack : bus.p1_rd_ack;
    endfunction

    function automatic logic g_wr_ack(input int p);
        return (p == 0) ? bus.p0_wr_ack : bus.p1_wr_ack;
    endfunction

    function automatic logic [15:0] g_d(input int p);
        return (p == 0) ? bus.p0_d : bus.p1_d;
    endfunction

    function automatic logic [31:0] g_grants(input int p);
        return (p == 0) ? grants0 : grants1;
    endfunction

    task automatic drive_port(input int p, input logic [15:0] a, input logic [15:0] q,
                              input bit trd, input bit twr);
        e_a[p] = a;
        e_q[p] = q;
        if (trd) m_rd_req[p] = ~m_rd_req[p];
        if (twr) m_wr_req[p] = ~m_wr_req[p];
        if (p == 0) begin
            bus.p0_a = a; bus.p0_q = q;
            bus.p0_rd_req = m_rd_req[0]; bus.p0_wr_req = m_wr_req[0];
        end else begin
            bus.p1_a = a; bus.p1_q = q;
            bus.p1_rd_req = m_rd_req[1]; bus.p1_wr_req = m_wr_req[1];
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_ack = 1'b0;
        bus.mem_d = '0;
        for (int p = 0; p < 2; p++) begin
            m_rd_req[p] = 1'b0; m_wr_req[p] = 1'b0;
            e_rd_ack[p] = 1'b0; e_wr_ack[p] = 1'b0;
            e_d[p] = '0; e_grants[p] = '0;
            drive_port(p, 16'h0, 16'h0, 1'b0, 1'b0);
        end
        e_last = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic ack_cycle(input logic [15:0] d);
        bus.mem_d = d;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({bus.mem_req, bus.mem_we, bus.mem_a, bus.mem_q} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_mem: req/we/a/q=%h required 0", {bus.mem_req, bus.mem_we, bus.mem_a, bus.mem_q});
        end
        n_tests++;
        if ({bus.p0_rd_ack, bus.p0_wr_ack, bus.p1_rd_ack, bus.p1_wr_ack, bus.p0_d, bus.p1_d} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_ports: acks/d=%h required 0",
                     {bus.p0_rd_ack, bus.p0_wr_ack, bus.p1_rd_ack, bus.p1_wr_ack, bus.p0_d, bus.p1_d});
        end
        n_tests++;
        if ({timeout, grants0, grants1} !== 65'h0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_status: timeout=%b g0=%0d g1=%0d state=%0d required 0/0/0/IDLE",
                     timeout, grants0, grants1, dbg_state);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        drive_port(0, 16'h1234, 16'hBEEF, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++;
        if ({bus.mem_req, bus.mem_we, bus.mem_a, bus.mem_q} !== {1'b1, 1'b1, 16'h1234, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL write_issue: req=%b we=%b a=%h q=%h required 1 1 1234 beef",
                     bus.mem_req, bus.mem_we, bus.mem_a, bus.mem_q);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL write_hold: mem_req=%b required 1", bus.mem_req);
        end
        ack_cycle(16'h0000);
        n_tests++;
        if ({bus.p0_wr_ack, bus.p0_rd_ack, bus.mem_req, grants0} !== {1'b1, 1'b0, 1'b0, 32'd1}) begin
            n_fail++;
            $display("FAIL write_done: wr_ack=%b rd_ack=%b mem_req=%b grants0=%0d required 1 0 0 1",
                     bus.p0_wr_ack, bus.p0_rd_ack, bus.mem_req, grants0);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        drive_port(1, 16'h0042, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++;
        if ({bus.mem_req, bus.mem_we, bus.mem_a} !== {1'b1, 1'b0, 16'h0042}) begin
            n_fail++;
            $display("FAIL read_issue: req=%b we=%b a=%h required 1 0 0042", bus.mem_req, bus.mem_we, bus.mem_a);
        end
        ack_cycle(16'hA5A5);
        n_tests++;
        if ({bus.p1_d, bus.p1_rd_ack, grants1, grants0} !== {16'hA5A5, 1'b1, 32'd1, 32'd0}) begin
            n_fail++;
            $display("FAIL read_done: p1_d=%h rd_ack=%b g1=%0d g0=%0d required a5a5 1 1 0",
                     bus.p1_d, bus.p1_rd_ack, grants1, grants0);
        end
    endtask

    task automatic test_contention();
        bit   ok;
        logic got;
        logic want;
        do_reset();
        drive_port(0, 16'h1000, 16'h0001, 1'b0, 1'b1);
        drive_port(1, 16'h2000, 16'h0002, 1'b0, 1'b1);
        exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            wait_req(ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL contention_wait: mem_req=0 after 20 cycles, required 1 (txn %0d)", k);
                break;
            end
            got  = (bus.mem_a == 16'h2000);
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL contention_order: txn %0d granted port %0d required port %0d", k, got, want);
            end
            ack_cycle(16'(k));
            n_tests++;
            if (bus.mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL contention_gap: mem_req=%b after ack, required 0", bus.mem_req);
            end
            drive_port(int'(got), e_a[got], e_q[got], 1'b0, 1'b1);
        end
    endtask

    task automatic test_rd_wr_same_port();
        bit ok;
        do_reset();
        drive_port(0, 16'h0077, 16'h5555, 1'b1, 1'b1);
        @(negedge clk);
        n_tests++;
        if ({bus.mem_req, bus.mem_we, bus.mem_q} !== {1'b1, 1'b1, 16'h5555}) begin
            n_fail++;
            $display("FAIL rdwr_first: req=%b we=%b q=%h required 1 1 5555", bus.mem_req, bus.mem_we, bus.mem_q);
        end
        ack_cycle(16'hFFFF);
        n_tests++;
        if ({bus.p0_wr_ack, bus.p0_rd_ack, bus.p0_d} !== {1'b1, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL rdwr_wdone: wr_ack=%b rd_ack=%b d=%h required 1 0 0000",
                     bus.p0_wr_ack, bus.p0_rd_ack, bus.p0_d);
        end
        wait_req(ok);
        n_tests++;
        if ({ok, bus.mem_we, bus.mem_a} !== {1'b1, 1'b0, 16'h0077}) begin
            n_fail++;
            $display("FAIL rdwr_second: seen=%b we=%b a=%h required 1 0 0077", ok, bus.mem_we, bus.mem_a);
        end
        ack_cycle(16'h3C3C);
        n_tests++;
        if ({bus.p0_rd_ack, bus.p0_d, grants0} !== {1'b1, 16'h3C3C, 32'd2}) begin
            n_fail++;
            $display("FAIL rdwr_rdone: rd_ack=%b d=%h g0=%0d required 1 3c3c 2", bus.p0_rd_ack, bus.p0_d, grants0);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        drive_port(1, 16'h0ABC, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        repeat (14) @(negedge clk);
        n_tests++;
        if ({timeout, bus.mem_req} !== 2'b01) begin
            n_fail++;
            $display("FAIL wd_early: timeout=%b mem_req=%b after 14 busy cycles, required 0 1", timeout, bus.mem_req);
        end
        @(negedge clk);
        n_tests++;
        if (timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_fire: timeout=%b after 15 busy cycles, required 1", timeout);
        end
        ack_cycle(16'h1111);
        n_tests++;
        if ({bus.p1_rd_ack, bus.p1_d, timeout, bus.mem_req} !== {1'b1, 16'h1111, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wd_late_ack: rd_ack=%b d=%h timeout=%b req=%b required 1 1111 1 0",
                     bus.p1_rd_ack, bus.p1_d, timeout, bus.mem_req);
        end
        drive_port(0, 16'h0001, 16'h0002, 1'b0, 1'b1);
        @(negedge clk);
        ack_cycle(16'h0000);
        n_tests++;
        if ({bus.p0_wr_ack, timeout} !== 2'b11) begin
            n_fail++;
            $display("FAIL wd_sticky: wr_ack=%b timeout=%b required 1 1", bus.p0_wr_ack, timeout);
        end
    endtask

    task automatic test_reset_busy();
        do_reset();
        drive_port(1, 16'h0300, 16'h0C0C, 1'b0, 1'b1);
        @(negedge clk);
        ack_cycle(16'h0000);
        drive_port(1, 16'h0301, 16'h0C0D, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++;
        if ({bus.mem_req, grants1} !== {1'b1, 32'd1}) begin
            n_fail++;
            $display("FAIL rstbusy_pre: req=%b g1=%0d required 1 1", bus.mem_req, grants1);
        end
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.mem_req, bus.p1_wr_ack, bus.p1_rd_ack, grants1} !== {3'b000, 32'd0} || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL rstbusy_abort: req=%b wr_ack=%b rd_ack=%b g1=%0d state=%0d required 0 0 0 0 IDLE",
                     bus.mem_req, bus.p1_wr_ack, bus.p1_rd_ack, grants1, dbg_state);
        end
        reset = 1'b0;
        e_wr_ack[1] = 1'b0;
        drive_port(1, 16'h0302, 16'h0C0E, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++;
        if ({bus.mem_req, bus.mem_we, bus.mem_a, bus.mem_q} !== {2'b11, 16'h0302, 16'h0C0E}) begin
            n_fail++;
            $display("FAIL rstbusy_reissue: req=%b we=%b a=%h q=%h required 1 1 0302 0c0e",
                     bus.mem_req, bus.mem_we, bus.mem_a, bus.mem_q);
        end
        ack_cycle(16'h0000);
        n_tests++;
        if ({bus.p1_wr_ack, grants1} !== {1'b1, 32'd1}) begin
            n_fail++;
            $display("FAIL rstbusy_done: wr_ack=%b g1=%0d required 1 1", bus.p1_wr_ack, grants1);
        end
    endtask

    task automatic test_random();
        int          n_done = 0;
        int          stall  = 0;
        int          delay  = 0;
        bit          in_txn = 1'b0;
        int          cur_p  = 0;
        int          exp_p;
        int          kind;
        bit          cur_we = 1'b0;
        logic [15:0] cur_md = '0;
        bit          pend [2];
        bit          pw   [2];
        do_reset();
        for (int cyc = 0; cyc < 4000 && n_done < 80; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                pw[p]   = m_wr_req[p] ^ e_wr_ack[p];
                pend[p] = pw[p] | (m_rd_req[p] ^ e_rd_ack[p]);
            end
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                if (cur_we) begin
                    e_wr_ack[cur_p] = ~e_wr_ack[cur_p];
                end else begin
                    e_rd_ack[cur_p] = ~e_rd_ack[cur_p];
                    e_d[cur_p]      = cur_md;
                end
                e_grants[cur_p] = e_grants[cur_p] + 32'd1;
                in_txn = 1'b0;
                n_done++;
                for (int p = 0; p < 2; p++) begin
                    n_tests++;
                    if ({g_rd_ack(p), g_wr_ack(p), g_d(p), g_grants(p)} !==
                        {e_rd_ack[p], e_wr_ack[p], e_d[p], e_grants[p]}) begin
                        n_fail++;
                        $display("FAIL rand_port%0d: rd_ack=%b wr_ack=%b d=%h grants=%0d required %b %b %h %0d",
                                 p, g_rd_ack(p), g_wr_ack(p), g_d(p), g_grants(p),
                                 e_rd_ack[p], e_wr_ack[p], e_d[p], e_grants[p]);
                    end
                end
                n_tests++;
                if (bus.mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_gap: mem_req=%b after ack, required 0", bus.mem_req);
                end
            end else if (!in_txn && bus.mem_req === 1'b1) begin
                n_tests++;
                if (!pend[0] && !pend[1]) begin
                    n_fail++;
                    $display("FAIL rand_spurious: mem_req=1 with nothing pending, required 0");
                end
                if (pend[0] && pend[1]) exp_p = e_last ? 0 : 1;
                else                    exp_p = pend[1] ? 1 : 0;
                n_tests++;
                if ({bus.mem_a, bus.mem_q, bus.mem_we} !== {e_a[exp_p], e_q[exp_p], pw[exp_p]}) begin
                    n_fail++;
                    $display("FAIL rand_grant: a=%h q=%h we=%b required port %0d a=%h q=%h we=%b",
                             bus.mem_a, bus.mem_q, bus.mem_we, exp_p, e_a[exp_p], e_q[exp_p], pw[exp_p]);
                end
                e_last = exp_p[0];
                cur_p  = exp_p;
                cur_we = pw[exp_p];
                in_txn = 1'b1;
                stall  = 0;
                delay  = $urandom_range(0, 8);
            end else if (!in_txn && (pend[0] || pend[1])) begin
                stall++;
                if (stall > 2) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rand_stall: mem_req=0 for %0d cycles with a request pending, required 1", stall);
                    break;
                end
            end else begin
                stall = 0;
            end
            if (in_txn && !bus.mem_ack) begin
                if (delay == 0) begin
                    cur_md      = 16'($urandom);
                    bus.mem_d   = cur_md;
                    bus.mem_ack = 1'b1;
                end else begin
                    delay--;
                end
            end
            for (int p = 0; p < 2; p++) begin
                pend[p] = (m_wr_req[p] ^ e_wr_ack[p]) | (m_rd_req[p] ^ e_rd_ack[p]);
                if (!pend[p] && $urandom_range(0, 3) == 0) begin
                    kind = $urandom_range(0, 2);
                    drive_port(p, 16'($urandom), 16'($urandom), kind != 1, kind != 0);
                end
            end
        end
        n_tests++;
        if (n_done < 80) begin
            n_fail++;
            $display("FAIL rand_progress: %0d transactions completed, required 80", n_done);
        end
        n_tests++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_timeout: timeout=%b with short ack delays, required 0", timeout);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_rd_wr_same_port();
        test_watchdog();
        test_reset_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_port_arb.md
# sdram_port_arb

Two-port arbiter that sits directly downstream of the SDRAM port testers (and any other toggle-handshake client). It accepts read/write requests on two toggle-style ports, grants them round-robin, and presents one level-handshake request at a time to the SDRAM controller's single client port. Read data is returned to the granted port, and a sticky watchdog flags a controller that never acknowledges.

## Interface
Parameters:
- addrwidth, 16, word address width; addresses are [addrwidth:1]
- datawidth, 16, data width
- timeoutwidth, 10, watchdog counter width; timeout after 2^timeoutwidth-1 cycles

Ports:
- clk  in  1  sole clock; everything is on the rising edge
- reset  in  1  synchronous, active-high reset
- pN_a  in  addrwidth  port N address (N=0,1); stable while pending
- pN_q  in  datawidth  port N write data; stable while pending
- pN_d  out  datawidth  port N read data; valid once pN_rd_ack toggles
- pN_rd_req  in  1  read request toggle
- pN_rd_ack  out  1  read acknowledge toggle
- pN_wr_req  in  1  write request toggle
- pN_wr_ack  out  1  write acknowledge toggle
- mem_a  out  addrwidth  controller address
- mem_q  out  datawidth  controller write data
- mem_we  out  1  1=write, 0=read
- mem_req  out  1  level request, held until mem_ack
- mem_ack  in  1  single-cycle completion pulse
- mem_d  in  datawidth  read data, valid in the mem_ack cycle
- timeout  out  1  sticky watchdog flag
- grants0, grants1  out  32  completed-transaction count per port

## Operation
- Pending conditions: rd pending = pN_rd_req ^ pN_rd_ack; wr pending = pN_wr_req ^ pN_wr_ack. Both are combinational from current registers.
- State machine IDLE:
  - No port pending: stay in IDLE.
  - Otherwise select a port. If only one port is pending, select it. If both are pending, select the port not in `last`.
  - Register the selected port in `sel` and update `last` to it.
  - Drive mem_a=pN_a, mem_q=pN_q, and mem_req=1.
  - Drive mem_we=1 if wr is pending on that port, else mem_we=0. Write wins when both rd and wr are pending on the same port.
  - Go to BUSY.
- State machine BUSY:
  - Hold mem_a, mem_q, mem_we, and mem_req.
  - On mem_ack: drop mem_req and toggle the matching ack of port `sel` (wr_ack if mem_we, else rd_ack).
  - On a read, also register pN_d<=mem_d in the same edge.
  - Increment grants[sel] and go to IDLE.
- Watchdog:
  - Counts BUSY cycles and clears on entry to BUSY.
  - When it reaches all-ones while still in BUSY, set timeout=1. Arbitration continues; timeout stays set until reset.
- mem_ack while in IDLE is ignored.
- Counters wrap modulo 2^32.
- Reset values:
  - State IDLE, last=1 (port 0 wins first tie), mem_req=0, mem_we=0.
  - mem_a=0, mem_q=0, all pN_d=0, all acks=0, timeout=0, grants=0.
- Reset mid-transaction abandons the in-flight request: mem_req drops, no ack toggles. A client whose req is 1 after reset is treated as pending and re-served. Clients resynchronise req to ack after reset.

## Timing
- Request toggle at edge T → mem_req=1 after edge T+1 (1 cycle in IDLE).
- mem_ack high in the cycle before edge K → ack toggled, pN_d updated, and mem_req=0, all after edge K.
- Next grant is issued at the earliest after edge K+1, so there is at least one mem_req-low cycle between transactions.
- With both ports continuously pending, grants alternate strictly 0,1,0,1.
- Outputs are registered; mem_ack→ack path is one register stage.

## Structure
- The shared package holds the state encoding (IDLE, BUSY) and the port index constants.
- One sub-module, `toggle_port`, instantiated twice, holds per-port logic:
  - rd/wr pending detection
  - the ack toggles
  - the pN_d register
  - the grant counter
- The arbiter FSM, mux, and watchdog are in the top level.

## Test plan
- Single write: toggle p0_wr_req, a=0x1234, q=0xBEEF; mem_ack 3 cycles later → mem_we=1, mem_a=0x1234, mem_q=0xBEEF; p0_wr_ack=1 after the ack edge; grants0=1.
- Single read: p1 read a=0x0042, mem_d=0xA5A5 with mem_ack → p1_d=0xA5A5 and p1_rd_ack toggles on the same edge.
- Contention: both ports toggle in the same cycle, out of reset, with immediate mem_ack → grant order 0,1,0,1 over 4 transactions; mem_req low ≥1 cycle between them.
- Same-port rd+wr pending together → write served first, then read.
- Watchdog (timeoutwidth=4): mem_ack withheld → timeout=1 after 15 BUSY cycles; a late mem_ack still completes; timeout stays 1.
- Reset during BUSY → mem_req=0 next edge, acks=0, grants=0; a request re-toggled after reset completes normally.
